// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with operand selection.
// Captures decoded fields and resolves RAW hazards for the execute-stage ALU:
// forwarding from EX/MEM and MEM/WB, load-use bubbles, stall and flush.
// Build option: define ID_EX_FORWARD_EN to enable the forwarding paths.
// When it is undefined, operands come only from the register file or the
// immediate, and any RAW dependency on an in-flight producer stalls decode.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              id_use_imm,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [3:0]        id_alu_op,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_rd_addr,
    input  logic [XLEN-1:0]   mwb_result,
    input  logic              stall,
    input  logic              flush,
    output logic              hazard_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic [3:0]        ex_alu_op,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
);

    // Forwarding source encodings reported on fwd_*_sel.
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXM = 2'd1;
    localparam logic [1:0] FWD_MWB = 2'd2;

    // Pipeline registers.
    logic              ex_valid_q,     ex_valid_d;
    logic [XLEN-1:0]   ex_op_a_q,      ex_op_a_d;
    logic [XLEN-1:0]   ex_op_b_q,      ex_op_b_d;
    logic [REG_AW-1:0] ex_rd_addr_q,   ex_rd_addr_d;
    logic [3:0]        ex_alu_op_q,    ex_alu_op_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q,  ex_mem_read_d;
    logic [1:0]        fwd_a_sel_q,    fwd_a_sel_d;
    logic [1:0]        fwd_b_sel_q,    fwd_b_sel_d;

    // Per-source view: index 0 is rs1, index 1 is rs2.
    logic [1:0][REG_AW-1:0] src_addr;
    logic [1:0][XLEN-1:0]   src_rdata;
    logic [1:0]             src_read;
    logic [1:0][XLEN-1:0]   src_val;
    logic [1:0][1:0]        src_sel;
    logic [1:0]             src_load_use;
    logic [1:0]             src_raw;

    assign src_addr[0]  = id_rs1_addr;
    assign src_addr[1]  = id_rs2_addr;
    assign src_rdata[0] = id_rs1_data;
    assign src_rdata[1] = id_rs2_data;
    // rs2 is not a real source when operand B is the immediate.
    assign src_read[0]  = 1'b1;
    assign src_read[1]  = ~id_use_imm;

    logic ex_rd_nz;
    assign ex_rd_nz = (ex_rd_addr_q != '0);

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic src_is_x0;
        assign src_is_x0 = (src_addr[gi] == '0);

        // A load in EX whose result this source needs cannot be forwarded yet.
        assign src_load_use[gi] = src_read[gi] && ex_rd_nz
                                  && (ex_rd_addr_q == src_addr[gi]);

`ifdef ID_EX_FORWARD_EN
        logic hit_exm;
        logic hit_mwb;
        assign hit_exm = exm_reg_write && (exm_rd_addr != '0)
                         && (exm_rd_addr == src_addr[gi]);
        assign hit_mwb = mwb_reg_write && (mwb_rd_addr != '0)
                         && (mwb_rd_addr == src_addr[gi]);

        // EX/MEM is younger than MEM/WB, so it takes priority.
        always_comb begin
            src_sel[gi] = FWD_RF;
            src_val[gi] = src_is_x0 ? '0 : src_rdata[gi];
            if (hit_exm) begin
                src_sel[gi] = FWD_EXM;
                src_val[gi] = exm_result;
            end else if (hit_mwb) begin
                src_sel[gi] = FWD_MWB;
                src_val[gi] = mwb_result;
            end
        end

        // Forwarding covers every non-load dependency.
        assign src_raw[gi] = 1'b0;
`else
        // Without forwarding, operands come straight from the register file.
        always_comb begin
            src_sel[gi] = FWD_RF;
            src_val[gi] = src_is_x0 ? '0 : src_rdata[gi];
        end

        // Any producer still in EX or EX/MEM blocks decode; once it reaches
        // MEM/WB the write-before-read register file supplies the value.
        logic raw_ex;
        logic raw_exm;
        assign raw_ex  = ex_valid_q && ex_reg_write_q && ex_rd_nz
                         && (ex_rd_addr_q == src_addr[gi]);
        assign raw_exm = exm_reg_write && (exm_rd_addr != '0)
                         && (exm_rd_addr == src_addr[gi]);
        assign src_raw[gi] = src_read[gi] && (raw_ex || raw_exm);
`endif
    end

`ifndef ID_EX_FORWARD_EN
    // MEM/WB and EX/MEM results have no consumer in this build.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mwb_reg_write, mwb_rd_addr, mwb_result, exm_result};
`endif

    // Hazard request: masked by stall/flush (they already decide the update)
    // and held low during reset so every output reads zero.
    logic load_use;
    logic raw_hazard;
    assign load_use     = ex_valid_q && ex_mem_read_q && id_valid && (|src_load_use);
    assign raw_hazard   = id_valid && (|src_raw);
    assign hazard_stall = (load_use || raw_hazard) && !stall && !flush && rst_n;

    // Next-state selection: flush > stall > hazard bubble > load.
    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_op_a_d      = ex_op_a_q;
        ex_op_b_d      = ex_op_b_q;
        ex_rd_addr_d   = ex_rd_addr_q;
        ex_alu_op_d    = ex_alu_op_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;
        fwd_a_sel_d    = fwd_a_sel_q;
        fwd_b_sel_d    = fwd_b_sel_q;
        if (flush || (!stall && hazard_stall)) begin
            // Bubble: kill controls, leave data fields as they were.
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            fwd_a_sel_d    = FWD_RF;
            fwd_b_sel_d    = FWD_RF;
        end else if (!stall) begin
            ex_valid_d     = id_valid;
            ex_op_a_d      = src_val[0];
            ex_op_b_d      = id_use_imm ? id_imm : src_val[1];
            ex_rd_addr_d   = id_rd_addr;
            ex_alu_op_d    = id_alu_op;
            ex_reg_write_d = id_valid && id_reg_write;
            ex_mem_read_d  = id_valid && id_mem_read;
            fwd_a_sel_d    = src_sel[0];
            fwd_b_sel_d    = id_use_imm ? FWD_RF : src_sel[1];
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_op_a_q      <= '0;
            ex_op_b_q      <= '0;
            ex_rd_addr_q   <= '0;
            ex_alu_op_q    <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            fwd_a_sel_q    <= FWD_RF;
            fwd_b_sel_q    <= FWD_RF;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_op_a_q      <= ex_op_a_d;
            ex_op_b_q      <= ex_op_b_d;
            ex_rd_addr_q   <= ex_rd_addr_d;
            ex_alu_op_q    <= ex_alu_op_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            fwd_a_sel_q    <= fwd_a_sel_d;
            fwd_b_sel_q    <= fwd_b_sel_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_op_a      = ex_op_a_q;
    assign ex_op_b      = ex_op_b_q;
    assign ex_rd_addr   = ex_rd_addr_q;
    assign ex_alu_op    = ex_alu_op_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign fwd_a_sel    = fwd_a_sel_q;
    assign fwd_b_sel    = fwd_b_sel_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: a driver applies directed and
// random decode/pipeline inputs, a reference model predicts the EX register
// contents after each edge, and a monitor compares them one cycle later.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid, id_use_imm, id_reg_write, id_mem_read;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_op;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd_addr, mwb_rd_addr;
    logic [31:0] exm_result, mwb_result;
    logic        stall, flush;
    logic        hazard_stall, ex_valid, ex_reg_write, ex_mem_read;
    logic [31:0] ex_op_a, ex_op_b;
    logic [4:0]  ex_rd_addr;
    logic [3:0]  ex_alu_op;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_rd_addr(id_rd_addr), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_result(mwb_result),
        .stall(stall), .flush(flush), .hazard_stall(hazard_stall),
        .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_rd_addr(ex_rd_addr), .ex_alu_op(ex_alu_op),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic        rw;
        logic        mr;
        logic [1:0]  sa;
        logic [1:0]  sb;
    } exp_t;

    exp_t m;          // model of what EX currently holds
    exp_t q[$];       // expected EX contents after the next edge
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_txn  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Value an operand source should deliver, and where it came from.
    function automatic logic [31:0] src_value(input logic [4:0] a, input logic [31:0] rf,
                                              output logic [1:0] sel);
        sel = 2'd0;
`ifdef ID_EX_FORWARD_EN
        if (exm_reg_write && exm_rd_addr != 0 && exm_rd_addr == a) begin
            sel = 2'd1;
            return exm_result;
        end
        if (mwb_reg_write && mwb_rd_addr != 0 && mwb_rd_addr == a) begin
            sel = 2'd2;
            return mwb_result;
        end
`endif
        return (a == 0) ? 32'd0 : rf;
    endfunction

    // Does the decode instruction read register r (r nonzero)?
    function automatic logic reads(input logic [4:0] r);
        return (r != 0) && (r == id_rs1_addr || (r == id_rs2_addr && !id_use_imm));
    endfunction

    function automatic logic model_hazard();
        logic h;
        h = id_valid && m.valid && m.mr && reads(m.rd);
`ifndef ID_EX_FORWARD_EN
        h = h || (id_valid && ((m.valid && m.rw && reads(m.rd)) ||
                               (exm_reg_write && reads(exm_rd_addr))));
`endif
        return h && !stall && !flush && rst_n;
    endfunction

    function automatic void model_update(input logic hz);
        logic [1:0] sa, sb;
        logic [31:0] va, vb;
        if (!rst_n) begin
            m = '0;
        end else if (flush || (!stall && hz)) begin
            m.valid = 0; m.rw = 0; m.mr = 0; m.sa = 0; m.sb = 0;
        end else if (!stall) begin
            va = src_value(id_rs1_addr, id_rs1_data, sa);
            vb = src_value(id_rs2_addr, id_rs2_data, sb);
            m.valid = id_valid;
            m.a     = va;
            m.b     = id_use_imm ? id_imm : vb;
            m.sa    = sa;
            m.sb    = id_use_imm ? 2'd0 : sb;
            m.rd    = id_rd_addr;
            m.op    = id_alu_op;
            m.rw    = id_valid && id_reg_write;
            m.mr    = id_valid && id_mem_read;
        end
    endfunction

    // One cycle: inputs were set right after a negedge; check the
    // combinational hazard request, predict the edge, wait for next negedge.
    task automatic step();
        logic hz;
        #1;
        hz = model_hazard();
        chk("hazard_stall", {31'd0, hazard_stall}, {31'd0, hz});
        model_update(hz);
        q.push_back(m);
        @(negedge clk);
    endtask

    task automatic idle();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
        id_imm = 0; id_use_imm = 0; id_rd_addr = 0; id_alu_op = 0;
        id_reg_write = 0; id_mem_read = 0;
        exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd_addr = 0; mwb_result = 0;
        stall = 0; flush = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic ld, input logic imm_en);
        id_valid = 1; id_rs1_addr = rs1; id_rs1_data = d1;
        id_rs2_addr = rs2; id_rs2_data = d2; id_rd_addr = rd;
        id_mem_read = ld; id_reg_write = 1; id_use_imm = imm_en;
        id_imm = 32'hFFFF_F123; id_alu_op = 4'h3;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
        chk({tag, "_op_a"}, ex_op_a, 32'd0);
        chk({tag, "_op_b"}, ex_op_b, 32'd0);
        chk({tag, "_rd"}, {27'd0, ex_rd_addr}, 32'd0);
        chk({tag, "_alu_op"}, {28'd0, ex_alu_op}, 32'd0);
        chk({tag, "_ctl"}, {30'd0, ex_reg_write, ex_mem_read}, 32'd0);
        chk({tag, "_sel"}, {28'd0, fwd_a_sel, fwd_b_sel}, 32'd0);
        chk({tag, "_hazard"}, {31'd0, hazard_stall}, 32'd0);
    endtask

    // Monitor: after every edge compare EX outputs against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_txn++;
                chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
                chk("ex_op_a", ex_op_a, e.a);
                chk("ex_op_b", ex_op_b, e.b);
                chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
                chk("ex_alu_op", {28'd0, ex_alu_op}, {28'd0, e.op});
                chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
                chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
                chk("fwd_a_sel", {30'd0, fwd_a_sel}, {30'd0, e.sa});
                chk("fwd_b_sel", {30'd0, fwd_b_sel}, {30'd0, e.sb});
                $display("txn %0d: valid=%b a=%h b=%h rd=%0d sel=%0d/%0d", n_txn,
                         ex_valid, ex_op_a, ex_op_b, ex_rd_addr, fwd_a_sel, fwd_b_sel);
            end
        end
    end

    initial begin
        idle();
        m = '0;
        // Power-on reset.
        #2 rst_n = 0;
        #1 check_all_zero("por");
        @(negedge clk);
        instr(5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1;
        step();                                          // first load after release
        idle(); step();

        // Forward priority: EX/MEM over MEM/WB over register file.
        instr(5'd5, 32'h33, 5'd6, 32'h66, 5'd9, 1'b0, 1'b0);
        exm_reg_write = 1; exm_rd_addr = 5'd5; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd_addr = 5'd5; mwb_result = 32'h22;
        step();
        exm_reg_write = 0;
        step();

        // x0 is never forwarded.
        instr(5'd4, 32'h44, 5'd0, 32'h0, 5'd8, 1'b0, 1'b0);
        exm_reg_write = 1; exm_rd_addr = 5'd0; exm_result = 32'hFFFF_FFFF;
        mwb_reg_write = 0;
        step();
        idle(); step();

        // Load-use on rs2, then the same dependency with an immediate B.
        instr(5'd1, 32'h10, 5'd2, 32'h20, 5'd7, 1'b1, 1'b0); step();
        instr(5'd2, 32'h30, 5'd7, 32'h70, 5'd9, 1'b0, 1'b0); step();
        exm_reg_write = 1; exm_rd_addr = 5'd7; exm_result = 32'hABCD;
        step();                                          // load forwarded now
        idle();
        instr(5'd1, 32'h10, 5'd2, 32'h20, 5'd7, 1'b1, 1'b0); step();
        instr(5'd2, 32'h30, 5'd7, 32'h70, 5'd9, 1'b0, 1'b1); step();
        idle(); step();

        // Stall holds for three cycles, then stall+flush kills.
        instr(5'd3, 32'h123, 5'd4, 32'h456, 5'd10, 1'b0, 1'b0); step();
        instr(5'd6, 32'h999, 5'd7, 32'h888, 5'd11, 1'b0, 1'b0);
        stall = 1; step(); step(); step();
        flush = 1; step();
        stall = 0; flush = 0; step();

        // Dependent ADDs on x3 with a modelled pipeline behind EX.
        idle();
        instr(5'd1, 32'h5, 5'd2, 32'h6, 5'd3, 1'b0, 1'b0); step();
        instr(5'd3, 32'h0, 5'd4, 32'h7, 5'd12, 1'b0, 1'b0); step();
        exm_reg_write = 1; exm_rd_addr = 5'd3; exm_result = 32'h77; step();
        exm_reg_write = 0; mwb_reg_write = 1; mwb_rd_addr = 5'd3; mwb_result = 32'h77;
        id_rs1_data = 32'h77; step();
        idle(); step();

        // Reset asserted mid-stall.
        instr(5'd1, 32'hAA, 5'd2, 32'hBB, 5'd13, 1'b1, 1'b0);
        stall = 1;
        rst_n = 0;
        m = '0;
        #1 check_all_zero("midrst");
        step(); step();
        rst_n = 1; stall = 0;
        step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            id_valid      = ($urandom_range(0, 4) != 0);
            id_rs1_addr   = 5'($urandom_range(0, 7));
            id_rs2_addr   = 5'($urandom_range(0, 7));
            id_rd_addr    = 5'($urandom_range(0, 7));
            id_rs1_data   = $urandom;
            id_rs2_data   = $urandom;
            id_imm        = $urandom;
            id_use_imm    = ($urandom_range(0, 2) == 0);
            id_alu_op     = 4'($urandom);
            id_reg_write  = ($urandom_range(0, 3) != 0);
            id_mem_read   = ($urandom_range(0, 2) == 0);
            exm_reg_write = $urandom_range(0, 1) == 1;
            exm_rd_addr   = 5'($urandom_range(0, 7));
            exm_result    = $urandom;
            mwb_reg_write = $urandom_range(0, 1) == 1;
            mwb_rd_addr   = 5'($urandom_range(0, 7));
            mwb_result    = $urandom;
            stall         = ($urandom_range(0, 7) == 0);
            flush         = ($urandom_range(0, 9) == 0);
            step();
        end
        idle();
        step();
        @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Decode-to-execute pipeline register and operand selector for the RV32I core. Captures decoded instruction fields each cycle, resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and presents registered signed 32-bit operands A/B to the execute-stage ALU (adder/subtractor). It also inserts load-use bubbles and honours stall and flush from the hazard/branch logic.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1_addr, id_rs2_addr  in  5  source register indices.
- id_rs1_data, id_rs2_data  in  32  register file read data; the register file is write-before-read.
- id_imm  in  32  sign-extended immediate.
- id_use_imm  in  1  operand B = immediate; rs2 is not read.
- id_rd_addr  in  5  destination index.
- id_alu_op  in  4  ALU operation code, passed through unchanged.
- id_reg_write, id_mem_read  in  1  writeback enable; instruction is a load.
- exm_reg_write  in  1  EX/MEM stage will write.
- exm_rd_addr  in  5  EX/MEM destination.
- exm_result  in  32  EX/MEM result.
- mwb_reg_write  in  1  MEM/WB stage will write.
- mwb_rd_addr  in  5  MEM/WB destination.
- mwb_result  in  32  MEM/WB result.
- stall  in  1  downstream freeze; hold all state.
- flush  in  1  kill the instruction entering EX (taken branch/jump).
- hazard_stall  out  1  combinational load-use stall request to fetch/decode.
- ex_valid  out  1  registered valid.
- ex_op_a, ex_op_b  out  32  registered signed operands to the ALU.
- ex_rd_addr  out  5  registered destination.
- ex_alu_op  out  4  registered op code.
- ex_reg_write, ex_mem_read  out  1  registered controls; forced 0 when ex_valid=0.
- fwd_a_sel, fwd_b_sel  out  2  registered forwarding source (0 regfile/imm, 1 EX/MEM, 2 MEM/WB), for debug.

## Operation
- Forward select per source, computed on the decode side: EX/MEM if exm_reg_write, exm_rd_addr!=0 and it equals the source index; else MEM/WB under the same rule; else register file data. EX/MEM has priority. x0 is never forwarded. A source that reads x0 yields 0.
- op_b: id_imm if id_use_imm, otherwise the forwarded rs2 value. fwd_b_sel=0 when id_use_imm.
- Load-use: hazard_stall=1 when all of the following hold: ex_valid, ex_mem_read, ex_rd_addr!=0, id_valid, and ex_rd_addr matches rs1, or matches rs2 with !id_use_imm.
- Register update, in priority order:
  - flush: bubble.
  - stall: hold all registers.
  - hazard_stall: bubble.
  - otherwise: load the decode fields.
- Bubble: ex_valid=0, ex_reg_write=0, ex_mem_read=0, fwd_*_sel=0. The data fields keep their previous values.
- hazard_stall is masked to 0 while stall is 1 or flush is 1.

## Timing
- Latency: 1 cycle from decode-side inputs to ex_* outputs.
- hazard_stall is combinational from the current ex_* registers and id_* inputs. The load-use bubble lasts exactly 1 cycle; on the next cycle the load sits in EX/MEM and is forwarded.
- Reset (async assert, synchronous release on the next clk edge): all outputs 0, including ex_op_a, ex_op_b, ex_rd_addr, ex_alu_op and fwd_*_sel.
- Reset mid-stall or mid-flush: the stage holds reset values until rst_n rises. The first edge after release loads normally.
- flush together with stall: flush wins, so the held instruction is killed.
- Under stall, operands are not re-forwarded. Forwarding resolves at capture time; the write-before-read register file covers later writebacks.

## Configuration
- ID_EX_FORWARD_EN defined: forwarding paths as described above.
- ID_EX_FORWARD_EN undefined: operands always come from the register file or immediate, and fwd_*_sel is tied to 0. hazard_stall additionally asserts for any RAW match against ex_rd_addr (with ex_valid, ex_reg_write) or exm_rd_addr (with exm_reg_write), rd!=0, and holds until the producer reaches MEM/WB.

## Test plan
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately; first edge after release loads id_* fields.
- Forward priority: exm_rd=mwb_rd=5, exm_result=0x11, mwb_result=0x22, id_rs1=5, id_rs1_data=0x33 -> ex_op_a=0x11, fwd_a_sel=1. Clear exm_reg_write -> ex_op_a=0x22, fwd_a_sel=2.
- x0 guard: exm_rd=0, exm_result=0xFFFFFFFF, id_rs2=0, id_rs2_data=0 -> ex_op_b=0, fwd_b_sel=0.
- Load-use: EX holds a load to rd=7; id_rs2=7, id_use_imm=0 -> hazard_stall=1, next ex_valid=0. With id_use_imm=1 -> no stall, ex_op_b=id_imm.
- Stall/flush: stall=1 for 3 cycles -> ex_* constant. stall=1 and flush=1 -> next ex_valid=0, ex_reg_write=0.
- Macro off: back-to-back dependent ADDs on x3 -> hazard_stall held until the producer reaches MEM/WB, then ex_op_a = regfile value.
